// File: rtl/memory_responder.sv
// Wait-stated memory responder: main RAM at 0x0000_xxxx, stack RAM at 0xD000_xxxx.
// Reads complete after WAIT wait states; writes commit immediately with no handshake.
module memory_responder #(
  parameter int WAIT   = 2,
  parameter int RAM_AW = 12,
  parameter int STK_AW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] memAddr,
  input  logic [15:0] memWrite,
  input  logic        memRE,
  input  logic        memWE,
  output logic [15:0] memRead,
  output logic        memReady,
  output logic        busErr
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic [31:0] r_addr;
  logic [31:0] w_rd_addr;
  logic [15:0] r_rdata, w_rd_data;
  logic        r_ready, r_err;
  logic        w_latch, w_capture;
  logic        w_wr_en, w_wr_main, w_wr_stk, w_rd_main, w_rd_stk, w_fwd;

  logic [15:0] r_main_mem [2**RAM_AW];
  logic [15:0] r_stk_mem  [2**STK_AW];

  // An offset at or above the region size falls outside the region.
  assign w_wr_main = (memAddr[31:16] == 16'h0000) && ((memAddr[15:0] >> RAM_AW) == 16'd0);
  assign w_wr_stk  = (memAddr[31:16] == 16'hD000) && ((memAddr[15:0] >> STK_AW) == 16'd0);
  assign w_wr_en   = memWE && !rst;

  // In IDLE the capture (WAIT=0 only) uses the live address; later it uses the latched one.
  assign w_rd_addr = (r_state == IDLE) ? memAddr : r_addr;
  assign w_rd_main = (w_rd_addr[31:16] == 16'h0000) && ((w_rd_addr[15:0] >> RAM_AW) == 16'd0);
  assign w_rd_stk  = (w_rd_addr[31:16] == 16'hD000) && ((w_rd_addr[15:0] >> STK_AW) == 16'd0);
  assign w_fwd     = w_wr_en && (memAddr == w_rd_addr);

  always_ff @(posedge clk) begin
    if (w_wr_en && w_wr_main) r_main_mem[memAddr[RAM_AW-1:0]] <= memWrite;
  end

  always_ff @(posedge clk) begin
    if (w_wr_en && w_wr_stk) r_stk_mem[memAddr[STK_AW-1:0]] <= memWrite;
  end

  // Write-first: a write landing on the location being captured returns the new data.
  always_comb begin
    w_rd_data = 16'h0000;
    if (w_rd_main) begin
      w_rd_data = w_fwd ? memWrite : r_main_mem[w_rd_addr[RAM_AW-1:0]];
    end else if (w_rd_stk) begin
      w_rd_data = w_fwd ? memWrite : r_stk_mem[w_rd_addr[STK_AW-1:0]];
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_latch      = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (memRE) begin
          w_latch    = 1'b1;
          w_cnt_next = 4'(WAIT);
          if (WAIT == 0) begin
            w_capture    = 1'b1;
            w_state_next = DONE;
          end else begin
            w_state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (!memRE) begin
          w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_capture    = 1'b1;
            w_state_next = DONE;
          end
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'h0000_0000;
      r_rdata <= 16'h0000;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_latch) r_addr <= memAddr;
      if (w_capture) r_rdata <= w_rd_data;
      r_ready <= w_capture;
      // Unmapped write errors land one cycle later; unmapped read errors ride with memReady.
      r_err   <= (memWE && !w_wr_main && !w_wr_stk) || (w_capture && !w_rd_main && !w_rd_stk);
    end
  end

  assign memRead  = r_rdata;
  assign memReady = r_ready;
  assign busErr   = r_err;
endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: one WAIT=2 and one WAIT=0 instance share the write bus.
// Expected read results are queued when a read starts and compared when memReady appears.
module tb_memory_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] memAddr = 32'h0;
  logic [15:0] memWrite = 16'h0;
  logic        memWE = 1'b0;
  logic        re2 = 1'b0, re0 = 1'b0;
  logic [15:0] rd2, rd0;
  logic        rdy2, rdy0, err2, err0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t q2[$];
  exp_t q0[$];
  logic [15:0] mdl_main [int];
  logic [15:0] mdl_stk  [int];
  logic [15:0] last2 = 16'h0;

  memory_responder #(.WAIT(2), .RAM_AW(12), .STK_AW(8)) u_dut2 (
    .clk(clk), .rst(rst), .memAddr(memAddr), .memWrite(memWrite), .memRE(re2),
    .memWE(memWE), .memRead(rd2), .memReady(rdy2), .busErr(err2)
  );

  memory_responder #(.WAIT(0), .RAM_AW(12), .STK_AW(8)) u_dut0 (
    .clk(clk), .rst(rst), .memAddr(memAddr), .memWrite(memWrite), .memRE(re0),
    .memWE(memWE), .memRead(rd0), .memReady(rdy0), .busErr(err0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  function automatic void model_read(input logic [31:0] a, output logic [15:0] d, output logic er);
    int off;
    off = int'(a[15:0]);
    d   = 16'h0000;
    er  = 1'b1;
    if (a[31:16] == 16'h0000 && off < 4096) begin
      er = 1'b0;
      if (mdl_main.exists(off)) d = mdl_main[off];
    end else if (a[31:16] == 16'hD000 && off < 256) begin
      er = 1'b0;
      if (mdl_stk.exists(off)) d = mdl_stk[off];
    end
  endfunction

  function automatic logic model_write(input logic [31:0] a, input logic [15:0] d);
    int off;
    off = int'(a[15:0]);
    if (a[31:16] == 16'h0000 && off < 4096) begin
      mdl_main[off] = d;
      return 1'b0;
    end
    if (a[31:16] == 16'hD000 && off < 256) begin
      mdl_stk[off] = d;
      return 1'b0;
    end
    return 1'b1;
  endfunction

  // Monitors: every memReady pulse must match the oldest queued expectation, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rdy2 === 1'b1) begin
      if (q2.size() == 0) check("w2 unexpected memReady", rdy2, 0);
      else begin
        e = q2.pop_front();
        $display("w2 read done cycle %0d data %04h err %0b", cyc, rd2, err2);
        check("w2 ready cycle", cyc, e.cyc);
        check("w2 memRead", rd2, e.data);
        check("w2 busErr", err2, e.err);
        last2 = e.data;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rdy0 === 1'b1) begin
      if (q0.size() == 0) check("w0 unexpected memReady", rdy0, 0);
      else begin
        e = q0.pop_front();
        $display("w0 read done cycle %0d data %04h err %0b", cyc, rd0, err0);
        check("w0 ready cycle", cyc, e.cyc);
        check("w0 memRead", rd0, e.data);
        check("w0 busErr", err0, e.err);
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [15:0] d);
    logic er;
    @(negedge clk);
    memAddr = a; memWrite = d; memWE = 1'b1;
    er = model_write(a, d);
    @(negedge clk);
    memWE = 1'b0;
    $display("write %08h <= %04h cycle %0d busErr %0b/%0b", a, d, cyc, err2, err0);
    check("write busErr w2", err2, er);
    check("write busErr w0", err0, er);
  endtask

  // Called at a negedge; the edge that follows samples memRE (cycle 0 of the access).
  task automatic start_exp(input bit w0, input logic [31:0] a, input logic [15:0] d, input logic er);
    exp_t e;
    memAddr = a;
    e.data = d; e.err = er;
    if (w0) begin e.cyc = cyc + 1; q0.push_back(e); re0 = 1'b1; end
    else    begin e.cyc = cyc + 3; q2.push_back(e); re2 = 1'b1; end
  endtask

  task automatic start_read(input bit w0, input logic [31:0] a);
    logic [15:0] d;
    logic er;
    model_read(a, d, er);
    start_exp(w0, a, d, er);
  endtask

  task automatic wait_ready(input bit w0);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      memWE = 1'b0;
      got = w0 ? (rdy0 === 1'b1) : (rdy2 === 1'b1);
      if (got) break;
    end
    re0 = 1'b0; re2 = 1'b0;
    if (!got) check("read timeout", 0, 1);
  endtask

  task automatic rd(input bit w0, input logic [31:0] a);
    @(negedge clk);
    start_read(w0, a);
    wait_ready(w0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b2b [3];
    logic        dummy;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset memReady w2", rdy2, 0);
    check("reset memRead w2", rd2, 0);
    check("reset busErr w2", err2, 0);
    check("reset memReady w0", rdy0, 0);
    check("reset memRead w0", rd0, 0);
    check("reset busErr w0", err0, 0);
    rst = 1'b0;

    // Basic read with WAIT=2 latency
    wr(32'h0000_0010, 16'hBEEF);
    rd(0, 32'h0000_0010);

    // Stack vs main RAM aliasing
    wr(32'hD000_0005, 16'h1234);
    wr(32'h0000_0005, 16'h5555);
    rd(0, 32'hD000_0005);
    rd(0, 32'h0000_0005);
    rd(1, 32'hD000_0005);

    // Unmapped reads: wrong page and offsets past each region
    rd(0, 32'h0001_0000);
    rd(0, 32'h0000_1000);
    rd(1, 32'hD000_0100);
    wr(32'h0000_0000, 16'hAAAA);
    wr(32'h8000_0000, 16'hDEAD);
    rd(0, 32'h0000_0000);
    rd(0, 32'h0000_0010);

    // Write during wait in cycle 1, then address wobble that must be ignored
    wr(32'h0000_0020, 16'h0001);
    @(negedge clk);
    start_exp(0, 32'h0000_0020, 16'h0002, 1'b0);
    dummy = model_write(32'h0000_0020, 16'h0002);
    @(negedge clk);
    memWrite = 16'h0002; memWE = 1'b1;
    @(negedge clk);
    memWE = 1'b0; memAddr = 32'h0000_0010;
    wait_ready(0);

    // Write in the capture cycle itself
    wr(32'h0000_0022, 16'h0005);
    @(negedge clk);
    start_exp(0, 32'h0000_0022, 16'h0006, 1'b0);
    dummy = model_write(32'h0000_0022, 16'h0006);
    @(negedge clk);
    @(negedge clk);
    memWrite = 16'h0006; memWE = 1'b1;
    wait_ready(0);

    // Simultaneous read request and write in IDLE, both wait settings
    @(negedge clk);
    memWrite = 16'h4444; memWE = 1'b1;
    dummy = model_write(32'h0000_0040, 16'h4444);
    start_read(0, 32'h0000_0040);
    wait_ready(0);
    @(negedge clk);
    memWrite = 16'h4141; memWE = 1'b1;
    dummy = model_write(32'h0000_0041, 16'h4141);
    start_read(1, 32'h0000_0041);
    wait_ready(1);

    // WAIT=0 back-to-back across three addresses
    b2b[0] = 32'h0000_0010; b2b[1] = 32'hD000_0005; b2b[2] = 32'h0000_0040;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start_read(1, b2b[k]);
      @(negedge clk);
    end
    re0 = 1'b0;
    repeat (3) @(negedge clk);

    // Abort by dropping memRE in BUSY (cycle 1 and capture-eligible cycle 2)
    for (int drop = 1; drop <= 2; drop++) begin
      @(negedge clk);
      memAddr = 32'h0000_0005; re2 = 1'b1;
      repeat (drop) @(negedge clk);
      re2 = 1'b0;
      repeat (5) @(negedge clk);
      $display("abort at cycle %0d of access: memRead %04h", drop, rd2);
      check("abort memRead held", rd2, last2);
    end
    rd(0, 32'h0000_0005);

    // Reset during BUSY, with a write attempted in the reset cycle
    wr(32'h0000_0030, 16'h3333);
    @(negedge clk);
    memAddr = 32'h0000_0010; re2 = 1'b1;
    @(negedge clk);
    rst = 1'b1; re2 = 1'b0;
    memAddr = 32'h0000_0030; memWrite = 16'h7777; memWE = 1'b1;
    @(negedge clk);
    rst = 1'b0; memWE = 1'b0;
    $display("reset in BUSY: memReady %0b memRead %04h", rdy2, rd2);
    check("reset-abort memReady", rdy2, 0);
    check("reset-abort memRead", rd2, 0);
    last2 = 16'h0000;
    repeat (4) @(negedge clk);
    rd(0, 32'h0000_0030);
    rd(1, 32'h0000_0030);

    repeat (4) @(negedge clk);
    check("w2 queue drained", q2.size(), 0);
    check("w0 queue drained", q0.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 The block SHALL expose parameter WAIT, default 2, meaning wait states added to every read (legal 0..15).
REQ-002 The block SHALL expose parameter RAM_AW, default 12, meaning the main RAM address width in 16-bit words.
REQ-003 The block SHALL expose parameter STK_AW, default 8, meaning the stack RAM address width in 16-bit words.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 memAddr  input  32  word address from the CPU.
REQ-007 memWrite  input  16  write data from the CPU.
REQ-008 memRE  input  1  read request, held high by the CPU until it samples memReady high.
REQ-009 memWE  input  1  single-cycle write strobe (the CPU never stalls on writes).
REQ-010 memRead  output  16  registered read data, valid while memReady=1.
REQ-011 memReady  output  1  registered, one-cycle read-complete pulse.
REQ-012 busErr  output  1  registered, one-cycle pulse on any access to an unmapped address.

Function
REQ-013 Decode: memAddr[31:16]=16'h0000 SHALL select main RAM at word memAddr[RAM_AW-1:0].
REQ-014 Decode: memAddr[31:16]=16'hD000 SHALL select stack RAM at word memAddr[STK_AW-1:0].
REQ-015 Decode: every other address, and any in-page offset at or above the region size, SHALL be unmapped.
REQ-016 Writes: memWE=1 SHALL commit memWrite to the decoded location at that clock edge, in any FSM state, with no handshake.
REQ-017 Unmapped writes SHALL be discarded and SHALL pulse busErr in the following cycle.
REQ-018 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-019 IDLE with memRE=1 SHALL latch memAddr and load the counter with WAIT, then go to BUSY; if WAIT=0 it SHALL go directly to DONE.
REQ-020 Addresses SHALL be latched only in IDLE; later changes to memAddr during the access SHALL be ignored.
REQ-021 BUSY SHALL decrement the counter each cycle.
REQ-022 When the counter is 1, BUSY SHALL read the latched location into memRead and go to DONE.
REQ-023 When WAIT=0, the array read into memRead SHALL occur on the IDLE->DONE edge.
REQ-024 DONE SHALL drive memReady=1 for exactly one cycle and then return to IDLE unconditionally.
REQ-025 Latency: with memRE first sampled in IDLE at cycle 0, memReady SHALL be high in cycle WAIT+1 and low in every other cycle of that access.
REQ-026 memRead SHALL hold its value until the next completed read.
REQ-027 memRE=0 in BUSY SHALL abort to IDLE with no memReady pulse and no change to memRead.
REQ-028 A read SHALL sample the array when the data is captured into memRead.
REQ-029 A write to the latched address before or in the capture cycle SHALL therefore be returned (write-first).
REQ-030 memRE=1 and memWE=1 on the same edge in IDLE SHALL perform the write and start the read; the read SHALL return the new data.
REQ-031 Unmapped reads SHALL complete with normal latency, return 16'h0000, and pulse busErr in the same cycle as memReady.
REQ-032 Back-to-back reads: memRE still high in the cycle after DONE SHALL start a new access from IDLE, with the minimum spacing of memReady pulses being WAIT+2 cycles.

Reset
REQ-033 rst=1 SHALL force state IDLE, counter 0, memReady=0, memRead=16'h0000 and busErr=0 at the next edge.
REQ-034 rst=1 SHALL block writes in the same cycle.
REQ-035 RAM contents SHALL NOT be cleared by reset.
REQ-036 Reset asserted during BUSY or DONE SHALL abort the access with no memReady pulse after reset deasserts.
REQ-037 The first request after reset SHALL see full WAIT+1 latency.

Verification
REQ-038 WAIT=2: write 16'hBEEF to 32'h0000_0010, then hold memRE at that address from cycle 0 -> memReady high only in cycle 3, memRead=16'hBEEF.
REQ-039 Stack: write 16'h1234 to 32'hD000_0005, read 32'hD000_0005 -> 16'h1234; read 32'h0000_0005 -> main RAM value, not 16'h1234.
REQ-040 Unmapped: read 32'h0001_0000 -> memRead=16'h0000 and busErr=1 in cycle WAIT+1; write 32'h8000_0000 -> busErr pulse in the next cycle, no RAM location changed.
REQ-041 Write during wait: start read of 32'h0000_0020 (old 16'h0001), write 16'h0002 to the same address in cycle 1 -> memRead=16'h0002.
REQ-042 WAIT=0 back-to-back: memRE held across three addresses -> memReady pulses every 2 cycles with correct data.
REQ-043 Abort and reset: drop memRE in BUSY, and separately assert rst in BUSY -> no memReady pulse; memRead unchanged for the drop case and 16'h0000 after reset; next read returns correct data with latency WAIT+1.
